// File: rtl/vram_dual_port_if.sv
// Port bundle for vram_dual_port: CPU write port A, scan-out read port B and clear control.
interface vram_dual_port_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  enable_a;
  logic                  write_a;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic                  ready_a;
  logic                  enable_b;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] data_out_b;
  logic                  valid_b;
  logic                  clear_req;
  logic                  busy;

  modport master (
    output enable_a, write_a, address_a, data_in_a, enable_b, address_b, clear_req,
    input  ready_a, data_out_b, valid_b, busy
  );

  modport slave (
    input  enable_a, write_a, address_a, data_in_a, enable_b, address_b, clear_req,
    output ready_a, data_out_b, valid_b, busy
  );
endinterface

// File: rtl/vram_dual_port.sv
// Single-clock dual-port video RAM: port A writes, port B pipelined reads, built-in clear engine.
module vram_dual_port #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RW_MODE      = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = {DATA_WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             reset,
  vram_dual_port_if.slave bus
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ready_a_q, ready_a_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  logic                  a_in_range_s, b_in_range_s, a_accept_s;
  logic [IDX_W-1:0]      idx_a_s, idx_b_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic                  s0_valid_q, s0_valid_d;
  logic [DATA_WIDTH-1:0] s0_data_q, s0_data_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  valid_b_q, valid_b_d;
  logic [DATA_WIDTH-1:0] data_out_b_q, data_out_b_d;
  logic                  tail_valid_s;
  logic [DATA_WIDTH-1:0] tail_data_s;

  assign a_in_range_s = ({1'b0, bus.address_a} < DEPTH_EXT);
  assign b_in_range_s = ({1'b0, bus.address_b} < DEPTH_EXT);
  assign idx_a_s      = bus.address_a[IDX_W-1:0];
  assign idx_b_s      = bus.address_b[IDX_W-1:0];
  // A clear request in the same cycle wins over the write, which is dropped.
  assign a_accept_s   = bus.enable_a & bus.write_a & ready_a_q & a_in_range_s & ~bus.clear_req;

  // Clear/run control and selection of the single array write per cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = CLEAR_VALUE;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {IDX_W{1'b0}};
        end else if (a_accept_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = idx_a_s;
          mem_wdata_s = bus.data_in_a;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
    busy_d    = (state_d == ST_CLEAR);
    ready_a_d = (state_d == ST_RUN);
  end

  // Port B lookup: reads during a clear report the fill word, whatever the progress.
  always_comb begin
    if (busy_q) begin
      rd_data_s = CLEAR_VALUE;
    end else if (!b_in_range_s) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else if ((RW_MODE == 1) && a_accept_s && (idx_a_s == idx_b_s)) begin
      rd_data_s = bus.data_in_a;
    end else begin
      rd_data_s = mem[idx_b_s];
    end
  end

  // Read pipeline: the lookup is captured at the request edge, then delayed to the output.
  always_comb begin
    s0_valid_d = bus.enable_b;
    s0_data_d  = rd_data_s;
    s1_valid_d = s0_valid_q;
    s1_data_d  = s0_data_q;
    if (READ_LATENCY == 2) begin
      tail_valid_s = s1_valid_q;
      tail_data_s  = s1_data_q;
    end else begin
      tail_valid_s = s0_valid_q;
      tail_data_s  = s0_data_q;
    end
    valid_b_d = tail_valid_s;
    if (tail_valid_s) begin
      data_out_b_d = tail_data_s;
    end else begin
      data_out_b_d = data_out_b_q;
    end
  end

  // State, control and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= {IDX_W{1'b0}};
      busy_q       <= 1'b1;
      ready_a_q    <= 1'b0;
      s0_valid_q   <= 1'b0;
      s0_data_q    <= {DATA_WIDTH{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_data_q    <= {DATA_WIDTH{1'b0}};
      valid_b_q    <= 1'b0;
      data_out_b_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      ready_a_q    <= ready_a_d;
      s0_valid_q   <= s0_valid_d;
      s0_data_q    <= s0_data_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      valid_b_q    <= valid_b_d;
      data_out_b_q <= data_out_b_d;
    end
  end

  // Storage array; no reset, the clear engine initialises it.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.ready_a    = ready_a_q;
  assign bus.busy       = busy_q;
  assign bus.valid_b    = valid_b_q;
  assign bus.data_out_b = data_out_b_q;

endmodule

// File: tb/tb_vram_dual_port.sv
// Scoreboard bench: three vram_dual_port configurations driven in lockstep, checked against a word-level model.
module tb_vram_dual_port;

  localparam int NI = 3;
  localparam int DEP  [NI] = '{16, 16, 1000};
  localparam int RLAT [NI] = '{1, 2, 2};
  localparam int RWM  [NI] = '{0, 1, 0};
  localparam int CLRV [NI] = '{32'hA5, 32'hA5, 32'h5A};

  typedef struct {
    int due;
    int data;
  } exp_t;

  logic clk = 1'b0;
  bit   rst, en_a, wr_a, en_b, clr;
  int   addr_a, din_a, addr_b;
  int   pos_cnt = 0;
  int   total = 0;
  int   bad = 0;
  bit   finish_req = 1'b0;

  logic [7:0] dout [NI];
  logic       vld  [NI];
  logic       bsy  [NI];
  logic       rdy  [NI];

  int   mem_m      [NI][1024];
  int   clear_left [NI];
  bit   exp_busy   [NI];
  logic [7:0] hold [NI];
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vram_dual_port_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) ifc ();
    assign ifc.enable_a  = en_a;
    assign ifc.write_a   = wr_a;
    assign ifc.address_a = 16'(addr_a);
    assign ifc.data_in_a = 8'(din_a);
    assign ifc.enable_b  = en_b;
    assign ifc.address_b = 16'(addr_b);
    assign ifc.clear_req = clr;
    assign dout[g] = ifc.data_out_b;
    assign vld[g]  = ifc.valid_b;
    assign bsy[g]  = ifc.busy;
    assign rdy[g]  = ifc.ready_a;

    vram_dual_port #(
      .DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(DEP[g]), .READ_LATENCY(RLAT[g]),
      .RW_MODE(RWM[g]), .CLEAR_VALUE(8'(CLRV[g]))
    ) u_dut (
      .clk(clk),
      .reset(rst),
      .bus(ifc.slave)
    );
  end

  function automatic int q_size(int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(int i);
    case (i)
      0: q0.delete(0);
      1: q1.delete(0);
      default: q2.delete(0);
    endcase
  endfunction

  function automatic void q_push(int i, exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic void q_clear(int i);
    case (i)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Reference model: evaluates the inputs about to be sampled at the next rising edge.
  task automatic model_step();
    int   ed, d;
    bit   bn, wok;
    exp_t ne;
    ed = pos_cnt + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        q_clear(i);
        clear_left[i] = DEP[i];
        for (int a = 0; a < DEP[i]; a++) mem_m[i][a] = CLRV[i];
      end else begin
        bn  = (clear_left[i] > 0);
        wok = !bn && en_a && wr_a && !clr && (addr_a < DEP[i]);
        if (en_b) begin
          if (bn) d = CLRV[i];
          else if (addr_b >= DEP[i]) d = 0;
          else if (RWM[i] == 1 && wok && addr_a == addr_b) d = din_a;
          else d = mem_m[i][addr_b];
          ne.due  = ed + RLAT[i];
          ne.data = d;
          q_push(i, ne);
        end
        if (wok) mem_m[i][addr_a] = din_a;
        if (bn) begin
          clear_left[i] = clear_left[i] - 1;
        end else if (clr) begin
          clear_left[i] = DEP[i];
          for (int a = 0; a < DEP[i]; a++) mem_m[i][a] = CLRV[i];
        end
      end
      exp_busy[i] = (clear_left[i] > 0);
    end
  endtask

  task automatic drive(bit r, bit ea, bit wa, int aa, int da, bit eb, int ab, bit c);
    rst = r; en_a = ea; wr_a = wa; addr_a = aa; din_a = da;
    en_b = eb; addr_b = ab; clr = c;
    model_step();
    @(negedge clk);
  endtask

  // Monitor: after every edge, compare valid/data/busy/ready of each instance with the scoreboard.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      bit   ev;
      ev = 1'b0;
      if (q_size(i) > 0) begin
        e  = q_front(i);
        ev = (e.due == pos_cnt);
      end
      if (rst) hold[i] = 8'h00;
      total++;
      if (vld[i] !== ev) begin
        bad++;
        $display("FAIL valid_b inst%0d edge %0d: got %b want %b", i, pos_cnt, vld[i], ev);
      end
      if (ev) begin
        q_pop(i);
        total++;
        if (dout[i] !== 8'(e.data)) begin
          bad++;
          $display("FAIL read_data inst%0d edge %0d: got %h want %h", i, pos_cnt, dout[i], 8'(e.data));
        end
        hold[i] = 8'(e.data);
      end else begin
        total++;
        if (dout[i] !== hold[i]) begin
          bad++;
          $display("FAIL hold_data inst%0d edge %0d: got %h want %h", i, pos_cnt, dout[i], hold[i]);
        end
      end
      while (q_size(i) > 0) begin
        e = q_front(i);
        if (e.due <= pos_cnt) q_pop(i);
        else break;
      end
      total++;
      if (bsy[i] !== exp_busy[i]) begin
        bad++;
        $display("FAIL busy inst%0d edge %0d: got %b want %b", i, pos_cnt, bsy[i], exp_busy[i]);
      end
      total++;
      if (rdy[i] !== !exp_busy[i]) begin
        bad++;
        $display("FAIL ready_a inst%0d edge %0d: got %b want %b", i, pos_cnt, rdy[i], !exp_busy[i]);
      end
    end
    if (finish_req || pos_cnt > 20000) begin
      if (!finish_req) begin
        bad++;
        $display("FAIL timeout edge %0d: got running want finished", pos_cnt);
      end
      for (int i = 0; i < NI; i++) begin
        total++;
        if (q_size(i) != 0) begin
          bad++;
          $display("FAIL drain inst%0d: got %0d pending want 0", i, q_size(i));
        end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0, 0, 0);
    // Clear after reset while port A keeps writing 8'h11 to address 3.
    for (int k = 0; k < 20; k++) drive(0, 1, 1, 3, 8'h11, 1, k % 16, 0);
    for (int k = 0; k < 16; k++) drive(0, 0, 0, 0, 0, 1, k, 0);
    for (int k = 0; k < 1000; k++)
      drive(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 0);
    // Latency and back-to-back reads.
    drive(0, 1, 1, 5, 8'h3C, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 0);
    drive(0, 0, 0, 0, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 6, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Same-address collision.
    drive(0, 1, 1, 7, 8'h01, 0, 0, 0);
    drive(0, 1, 1, 7, 8'h02, 1, 7, 0);
    drive(0, 0, 0, 0, 0, 1, 7, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Out-of-range write and reads.
    drive(0, 1, 1, 999, 8'h99, 0, 0, 0);
    drive(0, 1, 1, 1000, 8'hFF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1000, 0);
    drive(0, 0, 0, 0, 0, 1, 999, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomised traffic with occasional clear requests and resets.
    for (int k = 0; k < 400; k++) begin
      int aa, ab;
      aa = ($urandom_range(0, 3) == 0) ? 995 + $urandom_range(0, 9) : $urandom_range(0, 19);
      ab = ($urandom_range(0, 3) == 0) ? 995 + $urandom_range(0, 9) : $urandom_range(0, 19);
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            aa, $urandom_range(0, 255), 1'($urandom_range(0, 1)), ab,
            1'($urandom_range(0, 99) == 0));
    end
    for (int k = 0; k < 1100 && (exp_busy[0] || exp_busy[1] || exp_busy[2]); k++)
      drive(0, 0, 0, 0, 0, 1, k % 16, 0);
    // clear_req in RUN together with a write to address 2, then a second request mid-clear.
    for (int k = 0; k < 5; k++) drive(0, 1, 1, k, 8'h40 + k, 0, 0, 0);
    drive(0, 1, 1, 2, 8'h77, 1, 2, 1);
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 1, k, 0);
    drive(0, 1, 1, 2, 8'h66, 1, 2, 1);
    for (int k = 0; k < 1010; k++) drive(0, 0, 0, 0, 0, 1, k % 16, 0);
    // Reset at clear counter 8 with a read in flight.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 1010; k++) drive(0, 0, 0, 0, 0, 1, k % 16, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    finish_req = 1'b1;
  end

endmodule
